// File: rtl/store_uart_bridge.sv
// Memory-mapped UART transmitter fed from the core's store port.
// Stores to UART_ADDR queue a byte; queued bytes go out as 8N1 frames on tx.
module store_uart_bridge #(
  parameter logic [31:0] UART_ADDR    = 32'hFFFF_FF00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWriteM,
  input  logic [31:0]                   DataAdrM,
  input  logic [31:0]                   WriteDataM,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   Full     = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic push_req, clr_req, baud_last, pop, push, drop;

  always_comb begin
    push_req  = MemWriteM && (DataAdrM == UART_ADDR);
    clr_req   = MemWriteM && (DataAdrM == UART_ADDR + 32'd4) && WriteDataM[0];
    baud_last = (baud_q == BaudLast);
    pop       = (count_q != '0) &&
                ((state_q == StIdle) || ((state_q == StStop) && baud_last));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push      = push_req && ((count_q != Full) || pop);
    drop      = push_req && !push;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (clr_req) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop) begin
          state_d = StStart;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          if (pop) begin
            state_d = StStart;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= WriteDataM[7:0];
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_store_uart_bridge.sv
// Directed bench for store_uart_bridge (CLKS_PER_BIT = 4, FIFO_DEPTH = 8) with a
// free-running serial receiver that collects transmitted bytes.
module tb_store_uart_bridge;

  localparam logic [31:0] DataAddr = 32'hFFFF_FF00;
  localparam logic [31:0] CtrlAddr = 32'hFFFF_FF04;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteDataM;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];

  store_uart_bridge #(
    .UART_ADDR   (DataAddr),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWriteM (MemWriteM),
    .DataAdrM  (DataAdrM),
    .WriteDataM(WriteDataM),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge after the capturing edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWriteM  = 1'b1;
    DataAdrM   = addr;
    WriteDataM = data;
    @(negedge clk);
    MemWriteM  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = 32'hxxxx_xxxx;
    if (rx_q.size() > 0) got = {24'd0, rx_q.pop_front()};
    check(tag, got, {24'd0, exp});
  endtask

  // Receiver: samples 1.5 cycles into each 4-cycle bit cell.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        @(negedge clk);
        check("rx_start", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        check("rx_stop", {31'd0, tx}, 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] seq;
    reset = 1'b1;
    MemWriteM = 1'b0;
    DataAdrM = 32'd0;
    WriteDataM = 32'd0;
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: start, LSB-first data, stop.
    seq = 10'b11_0100_1010;  // index k holds bit k of the frame
    store(DataAddr, 32'hDEAD_BEA5);
    check("single_count1", {28'd0, fifo_count}, 32'd1);
    check("single_tx_hi", {31'd0, tx}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check($sformatf("single_tx_%0d", k), {31'd0, tx}, {31'd0, seq[k/4]});
      check("single_count0", {28'd0, fifo_count}, 32'd0);
      check("single_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("single_busy_drop", {31'd0, busy}, 32'd0);
    expect_byte("single_rx", 8'hA5);

    // Address filtering.
    store(32'hFFFF_FF08, 32'h41);
    DataAdrM = DataAddr;
    WriteDataM = 32'h42;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("filt_tx", {31'd0, tx}, 32'd1);
      check("filt_count", {28'd0, fifo_count}, 32'd0);
      check("filt_busy", {31'd0, busy}, 32'd0);
    end
    check("filt_rx_empty", rx_q.size(), 32'd0);

    // Back-to-back frames.
    store(DataAddr, 32'h01);
    store(DataAddr, 32'h02);
    store(DataAddr, 32'h03);
    check("b2b_peak", {28'd0, fifo_count}, 32'd2);
    for (int k = 0; k < 118; k++) begin
      @(negedge clk);
      check("b2b_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("b2b_busy_drop", {31'd0, busy}, 32'd0);
    check("b2b_rx_n", rx_q.size(), 32'd3);
    expect_byte("b2b_rx0", 8'h01);
    expect_byte("b2b_rx1", 8'h02);
    expect_byte("b2b_rx2", 8'h03);

    // Overflow: tenth byte is dropped.
    for (int i = 0; i < 10; i++) store(DataAddr, 32'h10 + 32'(i));
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {28'd0, fifo_count}, 32'd8);
    store(CtrlAddr, 32'h0);
    check("ovf_clr_bit0_zero", {31'd0, overflow}, 32'd1);
    store(CtrlAddr, 32'h1);
    check("ovf_clr", {31'd0, overflow}, 32'd0);
    wait_idle(500);
    check("ovf_rx_n", rx_q.size(), 32'd9);
    for (int i = 0; i < 9; i++) expect_byte("ovf_rx", 8'h10 + 8'(i));

    // Full FIFO with a push on the last stop cycle.
    for (int i = 0; i < 9; i++) store(DataAddr, 32'h20 + 32'(i));
    check("full_count", {28'd0, fifo_count}, 32'd8);
    check("full_ovf", {31'd0, overflow}, 32'd0);
    repeat (32) @(negedge clk);
    store(DataAddr, 32'h55);
    check("full_pushpop_count", {28'd0, fifo_count}, 32'd8);
    check("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
    wait_idle(500);
    check("full_rx_n", rx_q.size(), 32'd10);
    for (int i = 0; i < 9; i++) expect_byte("full_rx", 8'h20 + 8'(i));
    expect_byte("full_rx_last", 8'h55);

    // Reset during DATA bit 3 with three bytes queued.
    for (int i = 0; i < 4; i++) store(DataAddr, 32'h30 + 32'(i));
    check("rst_mid_count", {28'd0, fifo_count}, 32'd3);
    repeat (15) @(negedge clk);
    check("rst_mid_bit3", {31'd0, tx}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_count0", {28'd0, fifo_count}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    check("rst_mid_quiet", {31'd0, busy}, 32'd0);
    rx_q.delete();
    store(DataAddr, 32'h5A);
    wait_idle(100);
    check("rst_mid_rx_n", rx_q.size(), 32'd1);
    expect_byte("rst_mid_rx", 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
